dcache_wb_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between the CPU load/store port and mainDataReg.

---
 rtl/dcache_wb_controller_pkg.sv | 39 +++
 rtl/dcache_wb_controller_if.sv | 35 +++
 rtl/dcache_line_array.sv | 69 ++++++
 rtl/dcache_wb_controller.sv | 158 +++++++++++++++
 tb/tb_dcache_wb_controller.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_wb_controller_pkg.sv
// -----------------------------------------------------------------------------
// dcache_wb_controller_pkg
//   Shared geometry, derived address-field widths, FSM state encoding and an
//   address-assembly helper for the write-back data cache.
// -----------------------------------------------------------------------------
package dcache_wb_controller_pkg;

  localparam int ADDR_W    = 10;  // byte address width (1 KiB main memory)
  localparam int DATA_W    = 32;  // word width
  localparam int BLK_WORDS = 4;   // words per block, power of 2
  localparam int NUM_LINES = 4;   // cache lines, power of 2

  localparam int OFF_W = $clog2(BLK_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [OFF_W-1:0]  off_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  // Block-relative request captured at a miss; the byte offset is never needed.
  typedef struct packed {
    tag_t tag;
    idx_t idx;
  } req_t;

  // Word-aligned main-memory byte address {tag, index, word, 2'b00}.
  function automatic logic [ADDR_W-1:0] blk_addr(tag_t tag, idx_t idx, off_t off);
    return {tag, idx, off, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_wb_controller_if.sv
// -----------------------------------------------------------------------------
// dcache_wb_controller_if
//   Bundles the CPU load/store port and the main-memory word port.
//   slave  : the cache controller's view (CPU requests and memory responses in)
//   master : the environment's view (CPU + main memory driving the cache)
// -----------------------------------------------------------------------------
interface dcache_wb_controller_if;
  import dcache_wb_controller_pkg::*;

  // CPU side
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  word_t             cpu_wdata;
  word_t             cpu_rdata;
  logic              cpu_ready;
  // Main-memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  word_t             mem_wdata;
  word_t             mem_rdata;
  logic              mem_done;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_done,
    output cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_done,
    input  cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dcache_line_array.sv
// -----------------------------------------------------------------------------
// dcache_line_array
//   Tag / valid / dirty / data storage for a direct-mapped cache.
//   Reads are asynchronous (selected by i_idx / i_rd_off); writes happen on
//   the rising clock edge. Only valid and dirty bits are reset.
// Ports
//   clk, rst_n      clock, async active-low reset
//   i_idx           line selected for both read and write
//   i_rd_off        word selected for o_rdata
//   o_tag/o_valid/o_dirty/o_rdata   selected line state and word
//   i_data_we, i_wr_off, i_wdata    word write into line i_idx
//   i_dirty_set     mark line dirty (store hit)
//   i_dirty_clr     mark line clean (write-back finished)
//   i_fill, i_tag   refill finished: install tag, valid=1, dirty=0
// -----------------------------------------------------------------------------
module dcache_line_array
  import dcache_wb_controller_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  idx_t  i_idx,
  input  off_t  i_rd_off,
  output tag_t  o_tag,
  output logic  o_valid,
  output logic  o_dirty,
  output word_t o_rdata,
  input  logic  i_data_we,
  input  off_t  i_wr_off,
  input  word_t i_wdata,
  input  logic  i_dirty_set,
  input  logic  i_dirty_clr,
  input  logic  i_fill,
  input  tag_t  i_tag
);

  tag_t                 r_tag   [NUM_LINES];
  word_t                r_data  [NUM_LINES][BLK_WORDS];
  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;

  assign o_tag   = r_tag[i_idx];
  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_rdata = r_data[i_idx][i_rd_off];

  // NOTE: tag/data arrays have no reset; a line is meaningless until its
  // valid bit is set, and leaving them unreset lets them map onto RAM.
  always_ff @(posedge clk) begin
    if (i_data_we) r_data[i_idx][i_wr_off] <= i_wdata;
    if (i_fill)    r_tag[i_idx]            <= i_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_fill) begin
        r_valid[i_idx] <= 1'b1;
        r_dirty[i_idx] <= 1'b0;
      end else if (i_dirty_clr) begin
        r_dirty[i_idx] <= 1'b0;
      end else if (i_dirty_set) begin
        r_dirty[i_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_wb_controller.sv
// -----------------------------------------------------------------------------
// dcache_wb_controller
//   Direct-mapped, write-back, write-allocate data cache. Word hits complete
//   in the request cycle; a miss first writes back a dirty victim one word at
//   a time, then refills the block, then the held request hits.
// Ports
//   clk    clock, rising edge
//   rst_n  async active-low reset (aborts any miss in progress)
//   bus    dcache_wb_controller_if.slave: CPU port + main-memory word port
// -----------------------------------------------------------------------------
module dcache_wb_controller
  import dcache_wb_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  dcache_wb_controller_if.slave bus
);

  state_t r_state, w_state_nxt;
  off_t   r_cnt,   w_cnt_nxt;
  req_t   r_req;

  // CPU address fields
  tag_t w_cpu_tag;
  idx_t w_cpu_idx;
  off_t w_cpu_off;
  assign w_cpu_tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_cpu_idx = bus.cpu_addr[OFF_W+2 +: IDX_W];
  assign w_cpu_off = bus.cpu_addr[2 +: OFF_W];

  // Line array interface
  idx_t  w_idx;
  off_t  w_rd_off;
  tag_t  w_tag;
  logic  w_valid, w_dirty;
  word_t w_rdata;
  logic  w_data_we, w_dirty_set, w_dirty_clr, w_fill, w_latch_req;
  off_t  w_wr_off;
  word_t w_wdata;

  logic w_idle, w_req, w_hit, w_last;
  logic w_ready, w_mem_read, w_mem_write;
  logic [ADDR_W-1:0] w_mem_addr;

  assign w_idle = (r_state == ST_IDLE);
  assign w_req  = bus.cpu_read | bus.cpu_write;
  assign w_last = (r_cnt == off_t'(BLK_WORDS - 1));

  // In IDLE the array looks at the live CPU address; during a miss only the
  // latched request drives indexing, and the word counter selects the word.
  assign w_idx    = w_idle ? w_cpu_idx : r_req.idx;
  assign w_rd_off = w_idle ? w_cpu_off : r_cnt;
  assign w_hit    = w_idle && w_req && w_valid && (w_tag == w_cpu_tag);

  dcache_line_array u_lines (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_idx      (w_idx),
    .i_rd_off   (w_rd_off),
    .o_tag      (w_tag),
    .o_valid    (w_valid),
    .o_dirty    (w_dirty),
    .o_rdata    (w_rdata),
    .i_data_we  (w_data_we),
    .i_wr_off   (w_wr_off),
    .i_wdata    (w_wdata),
    .i_dirty_set(w_dirty_set),
    .i_dirty_clr(w_dirty_clr),
    .i_fill     (w_fill),
    .i_tag      (r_req.tag)
  );

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch_req) r_req <= '{tag: w_cpu_tag, idx: w_cpu_idx};
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = '0;
    w_data_we   = 1'b0;
    w_wr_off    = r_cnt;
    w_wdata     = bus.mem_rdata;
    w_dirty_set = 1'b0;
    w_dirty_clr = 1'b0;
    w_fill      = 1'b0;
    w_latch_req = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_ready = 1'b1;
          if (bus.cpu_write) begin   // store wins when both are asserted
            w_data_we   = 1'b1;
            w_wr_off    = w_cpu_off;
            w_wdata     = bus.cpu_wdata;
            w_dirty_set = 1'b1;
          end
        end else if (w_req) begin
          w_latch_req = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = (w_valid && w_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end

      ST_WRITEBACK: begin
        // Victim tag still sits in the array until the refill completes.
        w_mem_write = 1'b1;
        w_mem_addr  = blk_addr(w_tag, r_req.idx, r_cnt);
        if (bus.mem_done) begin
          w_cnt_nxt = r_cnt + 1'b1;   // wraps to 0 on the last word
          if (w_last) begin
            w_dirty_clr = 1'b1;
            w_state_nxt = ST_ALLOCATE;
          end
        end
      end

      ST_ALLOCATE: begin
        w_mem_read = 1'b1;
        w_mem_addr = blk_addr(r_req.tag, r_req.idx, r_cnt);
        if (bus.mem_done) begin
          w_data_we = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) begin
            w_fill      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.cpu_ready = w_ready;
  assign bus.cpu_rdata = w_hit ? w_rdata : '0;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = (r_state == ST_WRITEBACK) ? w_rdata : '0;

endmodule

// File: tb/tb_dcache_wb_controller.sv
// -----------------------------------------------------------------------------
// tb_dcache_wb_controller
//   Scoreboard bench. The reference model treats the cache as transparent
//   (a flat word memory) plus a direct-mapped tag directory that predicts
//   hits, misses, victim write-backs and latency. A monitor compares every
//   completed CPU request and every completed memory word transfer.
// -----------------------------------------------------------------------------
module tb_dcache_wb_controller;
  import dcache_wb_controller_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_wb_controller_if bus ();

  dcache_wb_controller dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic finish_now();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  typedef struct { bit is_read; logic [31:0] rdata; int base; } cpu_exp_t;
  typedef struct { bit is_write; logic [9:0] addr; logic [31:0] data; } mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  // Physical memory (byte array) and architectural view (word array)
  logic [7:0]  phys     [1024];
  logic [31:0] ref_word [256];
  bit          m_valid  [4];
  bit          m_dirty  [4];
  logic [3:0]  m_tag    [4];

  assign bus.mem_rdata = {phys[{bus.mem_addr[9:2], 2'd3}], phys[{bus.mem_addr[9:2], 2'd2}],
                          phys[{bus.mem_addr[9:2], 2'd1}], phys[{bus.mem_addr[9:2], 2'd0}]};

  task automatic sync_ref_from_phys();
    for (int w = 0; w < 256; w++)
      ref_word[w] = {phys[4*w+3], phys[4*w+2], phys[4*w+1], phys[4*w]};
  endtask

  // Reference: a transparent memory seen through a direct-mapped directory.
  task automatic model_req(input bit wr, input logic [9:0] addr, input logic [31:0] wd,
                           output cpu_exp_t e);
    logic [1:0] idx;
    logic [3:0] tag;
    mem_exp_t   m;
    idx = addr[5:4];
    tag = addr[9:6];
    e.base = 0;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      e.base = BLK_WORDS + 1;
      if (m_valid[idx] && m_dirty[idx]) begin
        e.base = 2 * BLK_WORDS + 1;
        for (int k = 0; k < 4; k++) begin
          m.is_write = 1'b1;
          m.addr     = {m_tag[idx], idx, 2'(k), 2'b00};
          m.data     = ref_word[m.addr[9:2]];
          mem_q.push_back(m);
        end
      end
      for (int k = 0; k < 4; k++) begin
        m.is_write = 1'b0;
        m.addr     = {tag, idx, 2'(k), 2'b00};
        m.data     = '0;
        mem_q.push_back(m);
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    e.is_read = !wr;
    e.rdata   = ref_word[addr[9:2]];
    if (wr) begin
      ref_word[addr[9:2]] = wd;
      m_dirty[idx]        = 1'b1;
    end
  endtask

  // Memory responder: mem_done pattern, settled shortly after each edge
  logic [9:0] stall_addr = '0;
  int         stall_left = 0;
  bit         rand_stall = 1'b0;

  initial bus.mem_done = 1'b1;
  always @(posedge clk) begin
    #2;
    if (bus.mem_read && stall_left > 0 && bus.mem_addr == stall_addr) begin
      bus.mem_done = 1'b0;
      stall_left--;
    end else if ((bus.mem_read || bus.mem_write) && rand_stall) begin
      bus.mem_done = ($urandom_range(0, 3) != 0);
    end else begin
      bus.mem_done = 1'b1;
    end
  end

  // Monitor / scoreboard
  int         waits = 0, stalls = 0, last_waits = 0;
  bit         prev_stall = 1'b0;
  logic [9:0] prev_addr = '0;
  logic [1:0] prev_kind = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      waits = 0; stalls = 0; prev_stall = 1'b0;
    end else begin
      if (bus.mem_read || bus.mem_write)
        check("mem_rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
      if (prev_stall) begin
        check("stall_holds_addr", 32'(bus.mem_addr), 32'(prev_addr));
        check("stall_holds_strobe", 32'({bus.mem_read, bus.mem_write}), 32'(prev_kind));
      end
      prev_stall = (bus.mem_read || bus.mem_write) && !bus.mem_done;
      prev_addr  = bus.mem_addr;
      prev_kind  = {bus.mem_read, bus.mem_write};
      if (prev_stall) stalls++;

      if ((bus.mem_read || bus.mem_write) && bus.mem_done) begin
        if (mem_q.size() == 0) begin
          check("unexpected_mem_access", 32'(bus.mem_addr), 32'h0000_0fff);
        end else begin
          mem_exp_t m;
          m = mem_q.pop_front();
          check("mem_is_write", 32'(bus.mem_write), 32'(m.is_write));
          check("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
          if (bus.mem_write) begin
            check("mem_wdata", bus.mem_wdata, m.data);
            {phys[{bus.mem_addr[9:2], 2'd3}], phys[{bus.mem_addr[9:2], 2'd2}],
             phys[{bus.mem_addr[9:2], 2'd1}], phys[{bus.mem_addr[9:2], 2'd0}]} = bus.mem_wdata;
          end
        end
      end

      if (bus.cpu_read || bus.cpu_write) begin
        if (!bus.cpu_ready) begin
          waits++;
        end else if (cpu_q.size() == 0) begin
          check("unexpected_cpu_ready", 32'd1, 32'd0);
        end else begin
          cpu_exp_t e;
          e = cpu_q.pop_front();
          check("cpu_wait_cycles", 32'(waits), 32'(e.base + stalls));
          if (e.is_read) check("cpu_rdata", bus.cpu_rdata, e.rdata);
          last_waits = waits;
          waits = 0;
          stalls = 0;
        end
      end
    end
  end

  // Driver: present a request and hold it until cpu_ready. Optionally assert
  // reset when the write-back reaches word abort_word.
  task automatic do_req(input bit rd, input bit wr, input logic [9:0] addr,
                        input logic [31:0] wd, input int abort_word = -1);
    cpu_exp_t e;
    bit       done = 1'b0;
    model_req(wr, addr, wd, e);
    cpu_q.push_back(e);
    bus.cpu_read  = rd;
    bus.cpu_write = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        done = 1'b1;
      end else if (abort_word >= 0 && bus.mem_write && bus.mem_addr[3:2] == 2'(abort_word)) begin
        #1 rst_n = 1'b0;
        return;
      end
    end
    if (!done) begin
      check("request_timeout", 32'd0, 32'd1);
      finish_now();
    end
    @(posedge clk);
    #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) phys[i] = (i < 256) ? 8'(i) : 8'($urandom);
    sync_ref_from_phys();
    for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end

    // Reset state, with a request held to prove cpu_ready stays low
    rst_n = 1'b0;
    bus.cpu_read = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = 10'h010; bus.cpu_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check("reset_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("reset_mem_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    bus.cpu_read = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_request_ready", 32'(bus.cpu_ready), 32'd0);
      check("idle_no_request_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    end
    @(posedge clk); #1;

    // Cold read miss, then a hit in the same block
    do_req(1, 0, 10'h010, '0);
    check("cold_miss_waits", 32'(last_waits), 32'd5);
    do_req(1, 0, 10'h014, '0);
    check("hit_waits", 32'(last_waits), 32'd0);

    // Store hit, then a conflicting read forces a dirty write-back
    do_req(0, 1, 10'h010, 32'hDEADBEEF);
    do_req(1, 0, 10'h110, '0);
    check("dirty_miss_waits", 32'(last_waits), 32'd9);
    check("writeback_bytes_0x010", {phys[10'h013], phys[10'h012], phys[10'h011], phys[10'h010]},
          32'hDEADBEEF);

    // Memory stalls 3 cycles on refill word 1
    stall_addr = 10'h014; stall_left = 3;
    do_req(1, 0, 10'h010, '0);
    check("stalled_miss_waits", 32'(last_waits), 32'd8);
    check("stall_consumed", 32'(stall_left), 32'd0);

    // Simultaneous read+write is a store; line becomes dirty
    do_req(1, 1, 10'h020, 32'h12345678);
    do_req(1, 0, 10'h020, '0);
    do_req(1, 0, 10'h120, '0);
    check("both_high_dirty_victim", 32'(last_waits), 32'd9);
    do_req(1, 0, 10'h020, '0);

    // Reset during write-back word 2
    do_req(0, 1, 10'h0A4, 32'hCAFEF00D);
    do_req(1, 0, 10'h1A0, '0, 2);
    @(negedge clk);
    check("midmiss_reset_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    check("midmiss_reset_ready", 32'(bus.cpu_ready), 32'd0);
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cpu_q.delete(); mem_q.delete();
    for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    sync_ref_from_phys();
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1, 0, 10'h010, '0);
    check("post_reset_reread_miss", 32'(last_waits), 32'd5);
    do_req(1, 0, 10'h0A4, '0);

    // Randomized traffic with random memory stalls
    rand_stall = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [3:0] tag;
      logic [9:0] a;
      bit         rd, wr;
      tag = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      a   = {tag, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      wr  = $urandom_range(0, 1) == 1;
      rd  = !wr || ($urandom_range(0, 7) == 0);
      do_req(rd, wr, a, $urandom);
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      #1;
    end
    rand_stall = 1'b0;

    repeat (3) @(posedge clk);
    check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    finish_now();
  end

endmodule
